// File: rtl/ram_seq_arb_if.sv
// Requester-side bundle for ram_seq_arb: two request ports plus the shared
// completion pulses and read-data return.
interface ram_seq_arb_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          done0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          done1;

  logic [DW-1:0] rdata;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  done0, done1, rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output done0, done1, rdata
  );
endinterface

// File: rtl/ram_seq_arb.sv
// Round-robin two-port arbiter and strobe sequencer for an asynchronous SRAM
// with active-low CS/OE/WE and a shared bidirectional data bus.
module ram_seq_arb #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int T_SETUP = 1,
  parameter int T_WRITE = 2,
  parameter int T_HOLD  = 1,
  parameter int T_READ  = 2
) (
  input  logic          clk,
  input  logic          rst,
  ram_seq_arb_if.slave  bus,
  output logic [AW-1:0] ram_a,
  inout  wire  [DW-1:0] ram_d,
  output logic          ram_cs_n,
  output logic          ram_oe_n,
  output logic          ram_we_n
);

  localparam int TMAX_A = (T_SETUP > T_WRITE) ? T_SETUP : T_WRITE;
  localparam int TMAX_B = (T_HOLD > T_READ) ? T_HOLD : T_READ;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int CW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    READ,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Latched request
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          port_q;
  logic          last_q;

  // RAM-facing and requester-facing output registers
  logic [AW-1:0] ram_a_q;
  logic [DW-1:0] dout_q;
  logic          drive_q, drive_d;
  logic          cs_n_q, cs_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic [DW-1:0] rdata_q;

  logic          grant;
  logic          grant_port;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant      = 1'b0;
    grant_port = port_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant      = 1'b1;
          // On a tie the port not served last wins; otherwise whoever asked.
          grant_port = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          state_d    = SETUP;
          cnt_d      = CW'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = we_q ? WRITE : READ;
          cnt_d   = we_q ? CW'(T_WRITE - 1) : CW'(T_READ - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD, READ: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are a registered decode of the current state, so the pins trail
  // the state by one cycle and nothing combinational reaches the RAM.
  always_comb begin
    cs_n_d  = !(state_q inside {SETUP, WRITE, HOLD, READ});
    we_n_d  = (state_q != WRITE);
    oe_n_d  = (state_q != READ);
    drive_d = we_q && (state_q inside {SETUP, WRITE, HOLD});
    done0_d = (state_q == DONE) && !port_q;
    done1_d = (state_q == DONE) && port_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    // NOTE: the whole datapath is reset, not just the control bits, so the
    // pins and rdata come out of reset at known values.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      port_q   <= 1'b0;
      last_q   <= 1'b1;
      ram_a_q  <= '0;
      dout_q   <= '0;
      drive_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        we_q    <= grant_port ? bus.we1    : bus.we0;
        addr_q  <= grant_port ? bus.addr1  : bus.addr0;
        wdata_q <= grant_port ? bus.wdata1 : bus.wdata0;
        port_q  <= grant_port;
      end
      if (state_q == DONE) begin
        last_q <= port_q;
      end
      // Address and data move only as CS falls, while WE and OE are high.
      if (state_q == SETUP) begin
        ram_a_q <= addr_q;
        dout_q  <= wdata_q;
      end
      // OE is still low on this edge: it is the last READ cycle on the pins.
      if (state_q == DONE && !we_q) begin
        rdata_q <= ram_d;
      end
      drive_q <= drive_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_d     = drive_q ? dout_q : {DW{1'bz}};
  assign ram_cs_n  = cs_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_ram_seq_arb.sv
// Directed bench for ram_seq_arb: default-timing instance A and slow-timing
// instance B, each with a small behavioural SRAM on its data bus.
module tb_ram_seq_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic use_b = 1'b0;

  always #5 clk = ~clk;

  // Shared stimulus, steered to one instance by use_b
  logic       req0_v = 1'b0, we0_v = 1'b0;
  logic       req1_v = 1'b0, we1_v = 1'b0;
  logic [7:0] addr0_v = '0, wdata0_v = '0;
  logic [7:0] addr1_v = '0, wdata1_v = '0;

  ram_seq_arb_if #(.AW(8), .DW(8)) if_a ();
  ram_seq_arb_if #(.AW(8), .DW(8)) if_b ();

  assign if_a.req0   = req0_v & ~use_b;
  assign if_a.req1   = req1_v & ~use_b;
  assign if_b.req0   = req0_v & use_b;
  assign if_b.req1   = req1_v & use_b;
  assign if_a.we0    = we0_v;
  assign if_a.we1    = we1_v;
  assign if_b.we0    = we0_v;
  assign if_b.we1    = we1_v;
  assign if_a.addr0  = addr0_v;
  assign if_a.addr1  = addr1_v;
  assign if_b.addr0  = addr0_v;
  assign if_b.addr1  = addr1_v;
  assign if_a.wdata0 = wdata0_v;
  assign if_a.wdata1 = wdata1_v;
  assign if_b.wdata0 = wdata0_v;
  assign if_b.wdata1 = wdata1_v;

  logic [7:0] ram_a_a, ram_a_b;
  wire  [7:0] ram_d_a, ram_d_b;
  logic       cs_n_a, oe_n_a, we_n_a;
  logic       cs_n_b, oe_n_b, we_n_b;

  ram_seq_arb dut_a (
    .clk      (clk),
    .rst      (rst),
    .bus      (if_a),
    .ram_a    (ram_a_a),
    .ram_d    (ram_d_a),
    .ram_cs_n (cs_n_a),
    .ram_oe_n (oe_n_a),
    .ram_we_n (we_n_a)
  );

  ram_seq_arb #(
    .AW(8), .DW(8), .T_SETUP(3), .T_WRITE(4), .T_HOLD(2), .T_READ(3)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .bus      (if_b),
    .ram_a    (ram_a_b),
    .ram_d    (ram_d_b),
    .ram_cs_n (cs_n_b),
    .ram_oe_n (oe_n_b),
    .ram_we_n (we_n_b)
  );

  // Behavioural asynchronous SRAMs: drive on CS&OE low, write on WE rising
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  assign ram_d_a = (!cs_n_a && !oe_n_a) ? mem_a[ram_a_a] : 8'bz;
  assign ram_d_b = (!cs_n_b && !oe_n_b) ? mem_b[ram_a_b] : 8'bz;

  always @(posedge we_n_a) if (!cs_n_a) mem_a[ram_a_a] <= ram_d_a;
  always @(posedge we_n_b) if (!cs_n_b) mem_b[ram_a_b] <= ram_d_b;

  // Observed view of whichever instance is selected
  logic       cs_n_m, oe_n_m, we_n_m, done0_m, done1_m;
  logic [7:0] a_m, d_m, rdata_m;

  assign cs_n_m  = use_b ? cs_n_b     : cs_n_a;
  assign oe_n_m  = use_b ? oe_n_b     : oe_n_a;
  assign we_n_m  = use_b ? we_n_b     : we_n_a;
  assign a_m     = use_b ? ram_a_b    : ram_a_a;
  assign d_m     = use_b ? ram_d_b    : ram_d_a;
  assign done0_m = use_b ? if_b.done0 : if_a.done0;
  assign done1_m = use_b ? if_b.done1 : if_a.done1;
  assign rdata_m = use_b ? if_b.rdata : if_a.rdata;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int done_cnt = 0;

  // Bus-rule monitor sampled mid-cycle
  logic       prev_wr = 1'b0;
  logic [7:0] prev_a = '0, prev_d = '0;

  always @(negedge clk) begin
    if (!oe_n_m && !we_n_m) viol++;
    if (!cs_n_m && !we_n_m && prev_wr && (a_m != prev_a || d_m != prev_d)) viol++;
    prev_wr = !cs_n_m && !we_n_m;
    prev_a  = a_m;
    prev_d  = d_m;
    if (done0_m || done1_m) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [7:0] addr, input logic [7:0] wdata);
    if (port == 0) begin
      req0_v = req; we0_v = we; addr0_v = addr; wdata0_v = wdata;
    end else begin
      req1_v = req; we1_v = we; addr1_v = addr; wdata1_v = wdata;
    end
  endtask

  task automatic drop_req(input int port);
    if (port == 0) req0_v = 1'b0;
    else           req1_v = 1'b0;
  endtask

  // One measured access; k counts edges after E0 (the first edge after req rises)
  task automatic access(input int port, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata,
                        output int lat, output int first_cs, output int cs_w,
                        output int first_we, output int we_w,
                        output int first_oe, output int oe_w,
                        output int dbad, output logic [7:0] rd, output logic to);
    lat = -1; first_cs = -1; cs_w = 0; first_we = -1; we_w = 0;
    first_oe = -1; oe_w = 0; dbad = 0; rd = '0; to = 1'b1;
    @(negedge clk);
    set_port(port, 1'b1, we, addr, wdata);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!cs_n_m) begin
        cs_w++;
        if (first_cs < 0) first_cs = k;
        if (we && d_m !== wdata) dbad++;
      end
      if (!we_n_m) begin
        we_w++;
        if (first_we < 0) first_we = k;
      end
      if (!oe_n_m) begin
        oe_w++;
        if (first_oe < 0) first_oe = k;
      end
      if ((port == 0 && done0_m) || (port == 1 && done1_m)) begin
        lat = k;
        rd  = rdata_m;
        to  = 1'b0;
        break;
      end
    end
    drop_req(port);
  endtask

  task automatic do_write(input string tag, input int port, input logic [7:0] addr,
                          input logic [7:0] data, input int exp_lat,
                          input int exp_we_start, input int exp_we_w, input int exp_cs_w);
    int lat, fcs, csw, fwe, wew, foe, oew, dbad;
    logic [7:0] rd;
    logic to;
    access(port, 1'b1, addr, data, lat, fcs, csw, fwe, wew, foe, oew, dbad, rd, to);
    check({tag, "_timeout"}, to, 1'b0);
    check({tag, "_done_edge"}, lat, exp_lat);
    check({tag, "_cs_start"}, fcs, 1);
    check({tag, "_cs_width"}, csw, exp_cs_w);
    check({tag, "_we_start"}, fwe, exp_we_start);
    check({tag, "_we_width"}, wew, exp_we_w);
    check({tag, "_oe_width"}, oew, 0);
    check({tag, "_dbus_bad"}, dbad, 0);
    check({tag, "_mem"}, use_b ? mem_b[addr] : mem_a[addr], data);
  endtask

  task automatic do_read(input string tag, input int port, input logic [7:0] addr,
                         input logic [7:0] exp_data, input int exp_lat,
                         input int exp_oe_start, input int exp_oe_w, input int exp_cs_w);
    int lat, fcs, csw, fwe, wew, foe, oew, dbad;
    logic [7:0] rd;
    logic to;
    access(port, 1'b0, addr, 8'h00, lat, fcs, csw, fwe, wew, foe, oew, dbad, rd, to);
    check({tag, "_timeout"}, to, 1'b0);
    check({tag, "_done_edge"}, lat, exp_lat);
    check({tag, "_cs_width"}, csw, exp_cs_w);
    check({tag, "_oe_start"}, foe, exp_oe_start);
    check({tag, "_oe_width"}, oew, exp_oe_w);
    check({tag, "_we_width"}, wew, 0);
    check({tag, "_rdata"}, rd, exp_data);
  endtask

  // Unmeasured request for the concurrent tests; logs which port completed
  int order[$];

  task automatic req_wait(input int port, input logic [7:0] addr, input logic [7:0] data);
    logic to;
    to = 1'b1;
    @(negedge clk);
    set_port(port, 1'b1, 1'b1, addr, data);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if ((port == 0 && done0_m) || (port == 1 && done1_m)) begin
        to = 1'b0;
        break;
      end
    end
    if (to) check("req_wait_timeout", to, 1'b0);
    else    order.push_back(port);
    drop_req(port);
  endtask

  initial begin
    int n;
    int dc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n_a, 1'b1);
    check("rst_oe_n", oe_n_a, 1'b1);
    check("rst_we_n", we_n_a, 1'b1);
    check("rst_ram_a", ram_a_a, 8'h00);
    check("rst_done0", if_a.done0, 1'b0);
    check("rst_done1", if_a.done1, 1'b0);
    check("rst_rdata", if_a.rdata, 8'h00);
    check("rst_b_cs_n", cs_n_b, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Single write then read-back on the default-timing instance
    do_write("wr_p0", 0, 8'h3C, 8'hA5, 5, 2, 2, 4);
    do_read("rd_p1", 1, 8'h3C, 8'hA5, 4, 2, 2, 3);

    // Simultaneous requests: port 0 first, then port 1
    order.delete();
    fork
      req_wait(0, 8'h01, 8'h11);
      req_wait(1, 8'h02, 8'h22);
    join
    check("tie_count", order.size(), 2);
    if (order.size() == 2) begin
      check("tie_first", order[0], 0);
      check("tie_second", order[1], 1);
    end
    do_read("tie_rd1", 0, 8'h01, 8'h11, 4, 2, 2, 3);
    do_read("tie_rd2", 1, 8'h02, 8'h22, 4, 2, 2, 3);

    // Both ports requesting back-to-back: grants must alternate
    order.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) req_wait(0, 8'(8'h10 + i), 8'(8'hB0 + i));
      end
      begin
        for (int i = 0; i < 3; i++) req_wait(1, 8'(8'h20 + i), 8'(8'hC0 + i));
      end
    join
    check("rr_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      check($sformatf("rr_grant%0d", i), order[i], i % 2);
    end

    // Reset during the second WRITE cycle
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 8'h50, 8'h77);
    n = 0;
    for (int k = 0; k < 32 && n < 2; k++) begin
      @(negedge clk);
      if (!we_n_a) n++;
    end
    check("mid_rst_reached", n, 2);
    rst = 1'b1;
    drop_req(0);
    dc = done_cnt;
    @(negedge clk);
    check("mid_rst_cs_n", cs_n_a, 1'b1);
    check("mid_rst_we_n", we_n_a, 1'b1);
    check("mid_rst_oe_n", oe_n_a, 1'b1);
    check("mid_rst_ram_a", ram_a_a, 8'h00);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_rst_no_done", done_cnt, dc);
    do_write("post_rst_wr", 1, 8'h60, 8'h99, 5, 2, 2, 4);
    do_read("post_rst_rd", 0, 8'h60, 8'h99, 4, 2, 2, 3);

    // Slow-timing instance: T_SETUP=3, T_WRITE=4, T_HOLD=2, T_READ=3
    @(negedge clk);
    use_b = 1'b1;
    do_write("b_wr", 0, 8'h21, 8'h5A, 10, 4, 4, 9);
    do_read("b_rd", 1, 8'h21, 8'h5A, 7, 4, 3, 6);
    @(negedge clk);
    use_b = 1'b0;

    check("bus_rule_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ram_seq_arb.md
# ram_seq_arb

Synchronous sequencer and two-port arbiter for the asynchronous `ram` primitive, which has active-low CS/OE/WE and a bidirectional data bus. It accepts word read/write requests from two clocked requesters and grants them round-robin. For the granted request it drives the RAM's address, data, and strobes, and holds each phase for a programmable number of cycles so the RAM's address-setup, write-width, and hold checks are met. On reads it captures the data word and returns it with a one-cycle completion pulse.

## Interface
- AW, 8, address width; equals RAM `A` width
- DW, 8, data width; equals RAM `D` width
- T_SETUP, 1, cycles with CS low and address/data stable before WE or OE falls (≥1)
- T_WRITE, 2, cycles WE held low (≥1)
- T_HOLD, 1, cycles address/data held after WE rises (≥1)
- T_READ, 2, cycles OE held low before data is sampled (≥1)
- clk  in  1  sole clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  request; held high with its fields stable until the matching done
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- done0 / done1  out  1  one-cycle completion pulse for the granted port
- rdata  out  DW  read data; valid in the done cycle, held until the next read completes
- ram_a  out  AW  to RAM `A`
- ram_d  inout  DW  to RAM `D`; driven only during the write phases, otherwise high-Z
- ram_cs_n, ram_oe_n, ram_we_n  out  1  RAM strobes, active-low

## Operation
- States: IDLE, SETUP, WRITE, HOLD, READ, DONE. A single down-counter times SETUP, WRITE, HOLD and READ.
- IDLE: strobes high, ram_d high-Z. The block samples req0/req1.
  - One requester high: grant it.
  - Both high: grant the port not served last. The last-served pointer resets to port 1, so port 0 wins the first tie.
  - On a grant, register we/addr/wdata and the port id, then go to SETUP.
- SETUP (T_SETUP cycles): ram_cs_n=0, ram_a=addr, OE and WE high. On a write, ram_d=wdata. Next state is WRITE if we=1, else READ.
- WRITE (T_WRITE cycles): ram_we_n=0, address and data unchanged, then HOLD.
- HOLD (T_HOLD cycles): ram_we_n=1, ram_cs_n=0, address and data still driven, then DONE.
- READ (T_READ cycles): ram_oe_n=0, ram_d high-Z. On the final READ cycle, register ram_d into rdata. Next state is DONE.
- DONE (1 cycle): all strobes high, ram_d released, done<port>=1, last-served pointer updated, then IDLE.
- Invariants:
  - ram_oe_n and ram_we_n are never both low.
  - ram_d is never driven while ram_oe_n=0.
  - ram_a and ram_d never change while ram_cs_n=0 and ram_we_n=0, so the RAM's address-change and data-change errors never fire.
- All RAM-facing outputs come straight from registers (no combinational paths from req).
- Reset values: ram_cs_n=ram_oe_n=ram_we_n=1, ram_a=0, ram_d high-Z, done0=done1=0, rdata=0, state IDLE, pointer=1.

## Timing
- Edge E0 is the edge at which IDLE samples the req. The done pulse is high after edge:
  - Write: E0+1+T_SETUP+T_WRITE+T_HOLD (defaults: E0+5).
  - Read: E0+1+T_SETUP+T_READ (defaults: E0+4).
- IDLE resamples on the edge after DONE. A req still high then is a new request, so the requester must drop req in the done cycle.
- Minimum gap between accesses is one IDLE cycle, with no strobes low.
- Simultaneous rising reqs are resolved round-robin; a port that was not granted keeps req high and is served next.
- Reset mid-access: on the reset edge every output returns to its reset value and no done is issued. The interrupted write may or may not have landed.
- A req that changes its fields before done is a protocol error; behaviour is undefined.

## Test plan
- Write port 0, addr 0x3C, data 0xA5, defaults → CS low from E0+1, WE low for exactly 2 cycles starting at E0+2, ram_d=0xA5 from E0+1 through E0+4, done0 at E0+5, RAM m[0x3C]=0xA5, no `$error`.
- Read port 1 of addr 0x3C → OE low for 2 cycles, rdata=0xA5 and done1 at E0+4, ram_d never driven by the controller.
- req0 and req1 both raised after reset (writes 0x01→0x11, 0x02→0x22) → port 0 is served first, then port 1. Read-back returns 0x11 and 0x22.
- Both ports requesting continuously for 6 accesses → grants alternate 0,1,0,1,0,1; no port is starved.
- rst asserted during the second WRITE cycle → all strobes high on the next edge, no done, next request is serviced normally.
- T_SETUP=3, T_WRITE=4, T_HOLD=2, T_READ=3 → done for a write at E0+10, for a read at E0+7; strobe widths match the parameters exactly.
